// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF reads and ME reads/writes onto one single-port memory with fixed latency
//  Optional feature macro ARB_RR_EN: round-robin arbitration (default: ME has fixed priority).
//  Ports: clock, reset_0 (async active-low)
//   IF: if_req, if_addr -> if_gnt, if_valid, if_rdata
//   ME: me_req, me_we, me_addr, me_wdata -> me_gnt, me_valid, me_rdata
//   memory: mem_en, mem_we, mem_addr, mem_wdata, mem_rdata
//   stall: combined pipeline freeze while either requester is unserved
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W = 4
) (
  input  logic        clock,
  input  logic        reset_0,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        me_req,
  input  logic        me_we,
  input  logic [31:0] me_addr,
  input  logic [31:0] me_wdata,
  output logic        me_gnt,
  output logic        me_valid,
  output logic [31:0] me_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAITING, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic owner, we_q, pick_me, start, last;
  // owner: 0 = IF, 1 = ME
  assign start = (state == IDLE) & (if_req | me_req);
  assign last = (cnt == CNT_W'(1));
`ifdef ARB_RR_EN
  logic last_owner;
  assign pick_me = me_req & (~if_req | ~last_owner);
  always_ff @(posedge clock or negedge reset_0)
    if (!reset_0) last_owner <= 1'b0;
    else if (start) last_owner <= pick_me;
`else
  assign pick_me = me_req;
`endif
  always_ff @(posedge clock or negedge reset_0)
    if (!reset_0) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (if_req | me_req) ? ACCESS : IDLE;
      ACCESS, WAITING: state_nx = last ? DONE : WAITING;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_0)
    if (!reset_0) begin
      cnt <= '0;
      owner <= 1'b0;
      we_q <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      me_rdata <= '0;
    end else if (start) begin
      cnt <= CNT_W'(MEM_LAT);
      owner <= pick_me;
      we_q <= pick_me & me_we;
      mem_addr <= pick_me ? me_addr : if_addr;
      mem_wdata <= pick_me ? me_wdata : '0;
    end else if (state == ACCESS || state == WAITING) begin
      cnt <= cnt - 1'b1;
      // read data is captured on the final latency cycle; writes leave rdata untouched
      if (last && !we_q && owner) me_rdata <= mem_rdata;
      if (last && !we_q && !owner) if_rdata <= mem_rdata;
    end
  always_comb begin
    mem_en = (state == ACCESS);
    mem_we = (state == ACCESS) & we_q;
    if_gnt = (state == ACCESS) & ~owner;
    me_gnt = (state == ACCESS) & owner;
    if_valid = (state == DONE) & ~owner;
    me_valid = (state == DONE) & owner;
  end
  assign stall = (if_req & ~if_valid) | (me_req & ~me_valid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table-driven checks of mem_port_arbiter at latency 3 and latency 1
module tb_mem_port_arbiter;
  localparam int LAT = 3;
  logic clock = 1'b0, reset_0 = 1'b0;
  always #5 clock = ~clock;
  logic if_req, me_req, me_we, if_gnt, if_valid, me_gnt, me_valid, mem_en, mem_we, stall;
  logic [31:0] if_addr, me_addr, me_wdata, mem_rdata, if_rdata, me_rdata, mem_addr, mem_wdata;
  logic if_req1, if_gnt1, if_valid1, me_gnt1, me_valid1, mem_en1, mem_we1, stall1;
  logic [31:0] if_addr1, mem_rdata1, if_rdata1, me_rdata1, mem_addr1, mem_wdata1;
  logic [31:0] mem [256];
  int tests = 0, fails = 0, en_cnt = 0;
  mem_port_arbiter #(.MEM_LAT(LAT), .CNT_W(4)) u3 (
    .clock(clock), .reset_0(reset_0), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata), .me_req(me_req), .me_we(me_we), .me_addr(me_addr),
    .me_wdata(me_wdata), .me_gnt(me_gnt), .me_valid(me_valid), .me_rdata(me_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall));
  mem_port_arbiter #(.MEM_LAT(1), .CNT_W(4)) u1 (
    .clock(clock), .reset_0(reset_0), .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
    .if_valid(if_valid1), .if_rdata(if_rdata1), .me_req(1'b0), .me_we(1'b0), .me_addr(32'h0),
    .me_wdata(32'h0), .me_gnt(me_gnt1), .me_valid(me_valid1), .me_rdata(me_rdata1), .mem_en(mem_en1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .stall(stall1));
  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_rdata1 = mem[mem_addr1[9:2]];
  always @(posedge clock) begin
    if (mem_en) en_cnt <= en_cnt + 1;
    if (!reset_0) begin
      mem[16] <= 32'h8C01_0004;
      mem[32] <= 32'hA5A5_0001;
    end else if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end
  typedef struct {
    bit me;
    bit we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_if;
    logic [31:0] exp_me;
  } vec_t;
  vec_t v[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_valid(input string name);
    int n = 0;
    while (!(if_valid | me_valid) && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_lat"}, n, LAT);
  endtask
  task automatic run(input bit me, input bit we, input logic [31:0] a, input logic [31:0] wd);
    int e0 = en_cnt;
    if (me) begin
      me_req = 1'b1; me_we = we; me_addr = a; me_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    @(negedge clock);
    chk("gnt", {if_gnt, me_gnt}, me ? 2'b01 : 2'b10);
    chk("mem_en_we", {mem_en, mem_we}, {1'b1, we});
    chk("mem_addr", mem_addr, a);
    if (we) chk("mem_wdata", mem_wdata, wd);
    chk("stall_busy", stall, 1);
    wait_valid("run");
    chk("valid", {if_valid, me_valid}, me ? 2'b01 : 2'b10);
    chk("stall_done", stall, 0);
    chk("en_once", en_cnt - e0, 1);
    if_req = 1'b0; me_req = 1'b0;
    @(negedge clock);
  endtask
  initial begin
    bit exp_me[4];
    int n, got;
    if_req = 0; me_req = 0; me_we = 0; if_addr = 0; me_addr = 0; me_wdata = 0;
    if_req1 = 0; if_addr1 = 0;
    v[0] = '{0, 0, 32'h40, 32'h0, 32'h8C01_0004, 32'h0};
    v[1] = '{1, 1, 32'h100, 32'hDEAD_BEEF, 32'h8C01_0004, 32'h0};
    v[2] = '{1, 1, 32'h200, 32'h1234_5678, 32'h8C01_0004, 32'h0};
    v[3] = '{1, 0, 32'h200, 32'h0, 32'h8C01_0004, 32'h1234_5678};
    v[4] = '{0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678};
    v[5] = '{1, 0, 32'h80, 32'h0, 32'hDEAD_BEEF, 32'hA5A5_0001};
`ifdef ARB_RR_EN
    exp_me = '{1, 0, 1, 0};
`else
    exp_me = '{1, 1, 1, 1};
`endif
    repeat (2) @(negedge clock);
    chk("rst_ctl", {if_gnt, me_gnt, if_valid, me_valid, mem_en, mem_we, stall}, 0);
    chk("rst_data", mem_addr | mem_wdata | if_rdata | me_rdata, 0);
    reset_0 = 1'b1;
    @(negedge clock);
    // latency-1 instance: single IF read
    if_addr1 = 32'h40; if_req1 = 1'b1;
    #1 chk("t1_stall_req", stall1, 1);
    @(negedge clock);
    chk("t1_gnt", {if_gnt1, mem_en1, mem_we1, stall1}, 4'b1101);
    @(negedge clock);
    chk("t1_valid", {if_valid1, stall1}, 2'b10);
    chk("t1_rdata", if_rdata1, 32'h8C01_0004);
    if_req1 = 1'b0;
    @(negedge clock);
    chk("t1_valid_pulse", if_valid1, 0);
    for (int i = 0; i < 6; i++) begin
      run(v[i].me, v[i].we, v[i].addr, v[i].wdata);
      chk($sformatf("vec%0d_if_rdata", i), if_rdata, v[i].exp_if);
      chk($sformatf("vec%0d_me_rdata", i), me_rdata, v[i].exp_me);
    end
    // reset during the wait phase of an IF read
    if_addr = 32'h40; if_req = 1'b1;
    @(negedge clock);
    chk("t5_gnt", if_gnt, 1);
    @(negedge clock);
    #1 reset_0 = 1'b0;
    #1 chk("t5_rst_ctl", {if_gnt, if_valid, mem_en, stall}, 4'b0001);
    chk("t5_rst_data", mem_addr | if_rdata | me_rdata, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t5_no_valid", if_valid, 0);
    end
    reset_0 = 1'b1;
    @(negedge clock);
    chk("t5_regnt", if_gnt, 1);
    wait_valid("t5");
    chk("t5_valid", if_valid, 1);
    chk("t5_rdata", if_rdata, 32'h8C01_0004);
    if_req = 1'b0;
    @(negedge clock);
    // simultaneous requests: ME first, IF after the following IDLE
    me_addr = 32'h200; me_we = 1'b0; if_addr = 32'h40;
    if_req = 1'b1; me_req = 1'b1;
    @(negedge clock);
    chk("t3_first", {if_gnt, me_gnt}, 2'b01);
    wait_valid("t3_me");
    chk("t3_me_valid", {if_valid, me_valid, stall}, 3'b011);
    chk("t3_me_rdata", me_rdata, 32'h1234_5678);
    me_req = 1'b0;
    @(negedge clock);
    chk("t3_idle", {if_gnt, stall}, 2'b01);
    @(negedge clock);
    chk("t3_if_gnt", {if_gnt, me_gnt}, 2'b10);
    wait_valid("t3_if");
    chk("t3_if_rdata", if_rdata, 32'h8C01_0004);
    if_req = 1'b0;
    @(negedge clock);
    // both held high: grant order and back-to-back spacing
    reset_0 = 1'b0;
    @(negedge clock);
    reset_0 = 1'b1;
    if_req = 1'b1; me_req = 1'b1; me_we = 1'b0;
    n = 0; got = 0;
    while (got < 4 && n < 60) begin
      @(negedge clock);
      n++;
      if (if_gnt | me_gnt) begin
        chk($sformatf("t4_gnt%0d", got), {if_gnt, me_gnt}, exp_me[got] ? 2'b01 : 2'b10);
        got++;
      end
    end
    chk("t4_count", got, 4);
    chk("t4_spacing", n, 1 + 3 * (LAT + 2));
    if_req = 1'b0; me_req = 1'b0;
    wait_valid("t4_last");
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
